// File: rtl/bist_dr.sv
// bist_dr: JTAG data-register block for a BIST engine. GETTEST loads
// fixed-length vectors into the engine; RUNBIST reads back a status word;
// every other instruction sees a one-bit bypass.
module bist_dr #(
  parameter int DEPTH  = 256,
  parameter int VEC_W  = 10,
  parameter int STAT_W = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int BC_W  = $clog2(VEC_W + 2)
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              TLR,
  input  logic              CAPTUREDR,
  input  logic              SHIFTDR,
  input  logic              UPDATEDR_ST,
  input  logic              GETTEST_SELECT,
  input  logic              RUNBIST_SELECT,
  input  logic              TDI,
  input  logic [STAT_W-1:0] BIST_STATUS,
  output logic              TDO,
  output logic [VEC_W-1:0]  BSR,
  output logic              UPDATEDR,
  output logic [CNT_W-1:0]  VEC_CNT,
  output logic              FULL,
  output logic              SHIFT_ERR
);

  typedef enum logic [1:0] {IDLE, CAPT, SHIFT, UPD} state_t;

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   load_sr;
  logic [STAT_W-1:0]  stat_sr;
  logic               byp;
  logic [BC_W-1:0]    bit_cnt;
  logic               do_cap, do_shift, do_upd, armed;
  logic               upd_ok, upd_err, sel_ld, sel_st;

  localparam logic [BC_W-1:0]  BC_MAX = BC_W'(VEC_W + 1);
  localparam logic [BC_W-1:0]  BC_LEN = BC_W'(VEC_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  // GETTEST wins when both selects are up
  assign sel_ld = GETTEST_SELECT;
  assign sel_st = !GETTEST_SELECT && RUNBIST_SELECT;
  assign FULL   = (VEC_CNT == CNT_MAX);

  // TDO shows the selected register's LSB only during Shift-DR
  always_comb begin
    TDO = 1'b0;
    if (SHIFTDR) begin
      if (sel_ld)      TDO = load_sr[0];
      else if (sel_st) TDO = stat_sr[0];
      else             TDO = byp;
    end
  end

  // Strobe priority, next-state and update qualification
  always_comb begin
    do_cap   = CAPTUREDR;
    do_shift = SHIFTDR && !CAPTUREDR;
    do_upd   = UPDATEDR_ST && !CAPTUREDR && !SHIFTDR;
    // an update only counts if a capture happened since the last update
    armed    = (state == CAPT) || (state == SHIFT);
    state_nxt = state;
    if (state == UPD) state_nxt = IDLE;
    if (do_cap)                 state_nxt = CAPT;
    else if (do_shift && armed) state_nxt = SHIFT;
    else if (do_upd && armed)   state_nxt = UPD;
    upd_ok  = do_upd && GETTEST_SELECT && !FULL && armed && (bit_cnt == BC_LEN);
    // a full session swallows updates silently, whatever their length
    upd_err = do_upd && GETTEST_SELECT && !FULL && !(armed && (bit_cnt == BC_LEN));
  end

  // FSM state register
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N)  state <= IDLE;
    else if (TLR) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture/shift path for the three scan registers and the bit counter
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      load_sr <= '0;
      stat_sr <= '0;
      byp     <= 1'b0;
      bit_cnt <= '0;
    end else if (TLR) begin
      load_sr <= '0;
      stat_sr <= '0;
      byp     <= 1'b0;
      bit_cnt <= '0;
    end else if (do_cap) begin
      load_sr <= '0;
      stat_sr <= BIST_STATUS;
      byp     <= 1'b0;
      bit_cnt <= '0;
    end else if (do_shift) begin
      if (sel_ld)      load_sr <= {TDI, load_sr[VEC_W-1:1]};
      else if (sel_st) stat_sr <= {TDI, stat_sr[STAT_W-1:1]};
      else             byp     <= TDI;
      if (bit_cnt != BC_MAX) bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  // Vector delivery, load pulse, session counter and sticky length error
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      BSR       <= '0;
      UPDATEDR  <= 1'b0;
      VEC_CNT   <= '0;
      SHIFT_ERR <= 1'b0;
    end else if (TLR) begin
      BSR       <= '0;
      UPDATEDR  <= 1'b0;
      VEC_CNT   <= '0;
      SHIFT_ERR <= 1'b0;
    end else begin
      UPDATEDR <= upd_ok;
      if (upd_ok) BSR <= load_sr;
      if (!GETTEST_SELECT) begin
        VEC_CNT   <= '0;
        SHIFT_ERR <= 1'b0;
      end else begin
        if (upd_ok)  VEC_CNT   <= VEC_CNT + CNT_W'(1);
        if (upd_err) SHIFT_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bist_dr.sv
// tb_bist_dr: scoreboard bench for bist_dr. Expected load vectors are queued
// when an update is issued; a negedge monitor pops one per UPDATEDR pulse.
module tb_bist_dr;
  localparam int DEPTH  = 4;
  localparam int VEC_W  = 10;
  localparam int STAT_W = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic TCK = 1'b0, TRST_N = 1'b0, TLR = 1'b0;
  logic CAPTUREDR = 1'b0, SHIFTDR = 1'b0, UPDATEDR_ST = 1'b0;
  logic GETTEST_SELECT = 1'b0, RUNBIST_SELECT = 1'b0, TDI = 1'b0;
  logic [STAT_W-1:0] BIST_STATUS = '0;
  logic              TDO;
  logic [VEC_W-1:0]  BSR;
  logic              UPDATEDR;
  logic [CNT_W-1:0]  VEC_CNT;
  logic              FULL;
  logic              SHIFT_ERR;

  bist_dr #(.DEPTH(DEPTH), .VEC_W(VEC_W), .STAT_W(STAT_W)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TLR(TLR), .CAPTUREDR(CAPTUREDR),
    .SHIFTDR(SHIFTDR), .UPDATEDR_ST(UPDATEDR_ST),
    .GETTEST_SELECT(GETTEST_SELECT), .RUNBIST_SELECT(RUNBIST_SELECT),
    .TDI(TDI), .BIST_STATUS(BIST_STATUS), .TDO(TDO), .BSR(BSR),
    .UPDATEDR(UPDATEDR), .VEC_CNT(VEC_CNT), .FULL(FULL), .SHIFT_ERR(SHIFT_ERR)
  );

  always #5 TCK = ~TCK;

  int checks = 0, failures = 0, pulses = 0;
  logic [VEC_W-1:0] exp_q[$];

  // reference model: what each register holds, in the spec's own terms
  logic [VEC_W-1:0]  m_load, m_bsr;
  logic [STAT_W-1:0] m_stat;
  logic              m_byp, m_err, m_armed, m_pulse;
  int                m_nb, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = '0; m_stat = '0; m_byp = 1'b0; m_bsr = '0;
    m_err = 1'b0; m_armed = 1'b0; m_pulse = 1'b0; m_nb = 0; m_cnt = 0;
  endtask

  // one TCK cycle with the given strobes; model advances by the spec's rules
  task automatic step(input logic cap, input logic sh, input logic up,
                      input logic tdi_b, input logic tlr_b);
    logic exp_tdo;
    logic have_push;
    logic [VEC_W-1:0] push_v;
    have_push = 1'b0; push_v = '0;
    CAPTUREDR = cap; SHIFTDR = sh; UPDATEDR_ST = up; TDI = tdi_b; TLR = tlr_b;
    #1;
    exp_tdo = 1'b0;
    if (sh) exp_tdo = GETTEST_SELECT ? m_load[0] : RUNBIST_SELECT ? m_stat[0] : m_byp;
    chk("tdo", 32'(TDO), 32'(exp_tdo));
    m_pulse = 1'b0;
    if (tlr_b) model_reset();
    else begin
      if (cap) begin
        m_load = '0; m_stat = BIST_STATUS; m_byp = 1'b0; m_nb = 0; m_armed = 1'b1;
      end else if (sh) begin
        if (GETTEST_SELECT)      m_load = {tdi_b, m_load[VEC_W-1:1]};
        else if (RUNBIST_SELECT) m_stat = {tdi_b, m_stat[STAT_W-1:1]};
        else                     m_byp  = tdi_b;
        if (m_nb < VEC_W + 1) m_nb++;
      end else if (up) begin
        if (GETTEST_SELECT && m_cnt != DEPTH) begin
          if (m_armed && m_nb == VEC_W) begin
            m_bsr = m_load; m_cnt++; m_pulse = 1'b1;
            have_push = 1'b1; push_v = m_load;
          end else m_err = 1'b1;
        end
        m_armed = 1'b0;
      end
      if (!GETTEST_SELECT) begin m_cnt = 0; m_err = 1'b0; end
    end
    @(posedge TCK);
    if (have_push) exp_q.push_back(push_v);
    #1;
    CAPTUREDR = 1'b0; SHIFTDR = 1'b0; UPDATEDR_ST = 1'b0; TLR = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_vec_cnt"},   32'(VEC_CNT),   32'(m_cnt));
    chk({tag, "_full"},      32'(FULL),      32'(m_cnt == DEPTH));
    chk({tag, "_shift_err"}, 32'(SHIFT_ERR), 32'(m_err));
    chk({tag, "_bsr"},       32'(BSR),       32'(m_bsr));
    chk({tag, "_updatedr"},  32'(UPDATEDR),  32'(m_pulse));
  endtask

  task automatic load_vec(input logic [VEC_W-1:0] v, input int nsh);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < nsh; i++) step(0, 1, 0, v[i % VEC_W], 0);
    step(0, 0, 1, 0, 0);
  endtask

  // scoreboard monitor: every pulse must match the oldest queued vector
  always @(negedge TCK) begin
    if (UPDATEDR === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pulse actual=1 required=0 bsr=%0h t=%0t", BSR, $time);
      end else begin
        chk("pulse_bsr", 32'(BSR), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int p0;
    logic [VEC_W-1:0] v4;
    model_reset();
    #12;
    check_status("reset");
    chk("reset_tdo", 32'(TDO), 32'd0);
    @(posedge TCK); #1; TRST_N = 1'b1;

    // known load vector, LSB first
    GETTEST_SELECT = 1'b1;
    step(0, 0, 0, 0, 0);
    load_vec(10'b1101001101, 10);
    check_status("vec1");
    step(0, 0, 0, 0, 0);
    chk("vec1_bsr_lit", 32'(BSR), 32'(10'b1101001101));
    chk("vec1_cnt_lit", 32'(VEC_CNT), 32'd1);
    chk("vec1_pulses", 32'(pulses), 32'd1);

    // short shift -> sticky error; session end clears it
    load_vec(VEC_W'($urandom), 9);
    check_status("short");
    chk("short_err_lit", 32'(SHIFT_ERR), 32'd1);
    chk("short_bsr_lit", 32'(BSR), 32'(10'b1101001101));
    GETTEST_SELECT = 1'b0;
    step(0, 0, 0, 0, 0);
    check_status("sess_end");
    chk("sess_end_err", 32'(SHIFT_ERR), 32'd0);

    // five loads into a depth-4 session
    GETTEST_SELECT = 1'b1;
    p0 = pulses; v4 = '0;
    for (int k = 0; k < 5; k++) begin
      logic [VEC_W-1:0] v;
      v = VEC_W'($urandom);
      if (k == 3) v4 = v;
      load_vec(v, 10);
      check_status("depth");
    end
    step(0, 0, 0, 0, 0);
    chk("depth_pulses", 32'(pulses - p0), 32'd4);
    chk("depth_full", 32'(FULL), 32'd1);
    chk("depth_bsr4", 32'(BSR), 32'(v4));
    GETTEST_SELECT = 1'b0;
    step(0, 0, 0, 0, 0);

    // status readout
    RUNBIST_SELECT = 1'b1; BIST_STATUS = 16'hA5F0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] seq;
      seq = 16'hA5F0;
      SHIFTDR = 1'b1; #1;
      chk("status_tdo_lit", 32'(TDO), 32'(seq[i]));
      step(0, 1, 0, $urandom_range(0, 1), 0);
    end
    step(0, 0, 1, 0, 0);
    check_status("status");
    RUNBIST_SELECT = 1'b0;

    // async reset mid-shift, then a clean load
    GETTEST_SELECT = 1'b1;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1'b1, 0);
    TRST_N = 1'b0; #1;
    model_reset();
    check_status("trst");
    @(posedge TCK); #1; TRST_N = 1'b1;
    p0 = pulses;
    v4 = VEC_W'($urandom);
    load_vec(v4, 10);
    step(0, 0, 0, 0, 0);
    chk("trst_pulses", 32'(pulses - p0), 32'd1);
    chk("trst_bsr", 32'(BSR), 32'(v4));

    // capture and update together -> capture only; TLR beats strobes
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, $urandom_range(0, 1), 0);
    p0 = pulses;
    step(1, 0, 1, 0, 0);
    check_status("cap_upd");
    step(0, 0, 0, 0, 0);
    chk("cap_upd_pulses", 32'(pulses - p0), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, $urandom_range(0, 1), 0);
    step(1, 1, 1, 0, 1);
    check_status("tlr");
    step(0, 0, 1, 0, 0);
    check_status("after_tlr");

    // randomized sessions
    for (int n = 0; n < 60; n++) begin
      int r, nsh;
      r = $urandom_range(0, 9);
      GETTEST_SELECT = (r < 7);
      RUNBIST_SELECT = $urandom_range(0, 1);
      BIST_STATUS = STAT_W'($urandom);
      if ($urandom_range(0, 9) != 0) step(1, 0, 0, 0, 0);
      nsh = $urandom_range(8, 11);
      for (int i = 0; i < nsh; i++) step(0, 1, 0, $urandom_range(0, 1), 0);
      step(0, 0, 1, 0, 0);
      check_status("rand");
      if ($urandom_range(0, 4) == 0) step(0, 0, 0, 0, $urandom_range(0, 3) == 0);
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
